// File: rtl/psr_ctrl_pkg.sv
// Shared definitions for the PSR controller: mode encodings, exception codes,
// vector offsets, FSM state codes and the CPSR reset value.
package psr_ctrl_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [2:0] EXC_UNDEF = 3'd0;
  localparam logic [2:0] EXC_SVC   = 3'd1;
  localparam logic [2:0] EXC_PABT  = 3'd2;
  localparam logic [2:0] EXC_DABT  = 3'd3;
  localparam logic [2:0] EXC_IRQ   = 3'd4;
  localparam logic [2:0] EXC_FIQ   = 3'd5;

  localparam logic [31:0] CPSR_RESET = 32'h0000_01D3;
  localparam logic [3:0]  LINK_REG   = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_LINK = 2'd2,
    ST_VECT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    BANK_FIQ,
    BANK_IRQ,
    BANK_SVC,
    BANK_ABT,
    BANK_UND,
    BANK_NONE
  } bank_t;

  function automatic logic exc_valid(input logic [2:0] t);
    return t <= EXC_FIQ;
  endfunction

  function automatic logic [4:0] exc_mode(input logic [2:0] t);
    case (t)
      EXC_UNDEF:          return MODE_UND;
      EXC_SVC:            return MODE_SVC;
      EXC_PABT, EXC_DABT: return MODE_ABT;
      EXC_IRQ:            return MODE_IRQ;
      EXC_FIQ:            return MODE_FIQ;
      default:            return MODE_SVC;
    endcase
  endfunction

  function automatic logic [31:0] exc_vector(input logic [2:0] t);
    case (t)
      EXC_UNDEF: return 32'h04;
      EXC_SVC:   return 32'h08;
      EXC_PABT:  return 32'h0C;
      EXC_DABT:  return 32'h10;
      EXC_IRQ:   return 32'h18;
      EXC_FIQ:   return 32'h1C;
      default:   return 32'h00;
    endcase
  endfunction

  function automatic bank_t mode_bank(input logic [4:0] m);
    case (m)
      MODE_FIQ: return BANK_FIQ;
      MODE_IRQ: return BANK_IRQ;
      MODE_SVC: return BANK_SVC;
      MODE_ABT: return BANK_ABT;
      MODE_UND: return BANK_UND;
      default:  return BANK_NONE;
    endcase
  endfunction

  function automatic logic mode_known(input logic [4:0] m);
    return (mode_bank(m) != BANK_NONE) || (m == MODE_USR) || (m == MODE_SYS);
  endfunction

endpackage

// File: rtl/psr_ctrl_if.sv
// Exception, PSR-write and register-file port bundle of the PSR controller.
interface psr_ctrl_if;
  logic        exc_req;
  logic [2:0]  exc_type;
  logic [31:0] exc_ret_addr;
  logic        exc_ack;
  logic        eret;
  logic        msr_we;
  logic        msr_spsr;
  logic [31:0] msr_data;
  logic [4:0]  M;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic        write_reg;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        write_pc;
  logic [31:0] pc_data;
  logic        busy;

  modport master (
    output exc_req, exc_type, exc_ret_addr, eret, msr_we, msr_spsr, msr_data,
    input  exc_ack, M, cpsr, spsr, write_reg, w_addr, w_data, write_pc, pc_data, busy
  );

  modport slave (
    input  exc_req, exc_type, exc_ret_addr, eret, msr_we, msr_spsr, msr_data,
    output exc_ack, M, cpsr, spsr, write_reg, w_addr, w_data, write_pc, pc_data, busy
  );
endinterface

// File: rtl/psr_spsr_bank.sv
// Five banked SPSRs (fiq, irq, svc, abt, und) with mode-indexed write and read;
// modes without a bank read as zero and ignore writes.
module psr_spsr_bank
  import psr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wmode,
  input  logic [31:0] wdata,
  input  logic [4:0]  rmode,
  output logic [31:0] rdata
);

  logic [31:0] fiq_q, irq_q, svc_q, abt_q, und_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fiq_q <= '0;
      irq_q <= '0;
      svc_q <= '0;
      abt_q <= '0;
      und_q <= '0;
    end else if (we) begin
      case (mode_bank(wmode))
        BANK_FIQ: fiq_q <= wdata;
        BANK_IRQ: irq_q <= wdata;
        BANK_SVC: svc_q <= wdata;
        BANK_ABT: abt_q <= wdata;
        BANK_UND: und_q <= wdata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (mode_bank(rmode))
      BANK_FIQ: rdata = fiq_q;
      BANK_IRQ: rdata = irq_q;
      BANK_SVC: rdata = svc_q;
      BANK_ABT: rdata = abt_q;
      BANK_UND: rdata = und_q;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/psr_ctrl.sv
// PSR controller: CPSR, banked SPSRs, exception entry sequencing, eret and MSR.
// state | meaning
// IDLE  | accept exception / eret / msr
// SAVE  | SPSR[target] <= CPSR, CPSR switches to target mode
// LINK  | write return address to banked r14
// VECT  | write vector to PC, pulse exc_ack
module psr_ctrl
  import psr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  psr_ctrl_if.slave   bus
);

  state_t      state_q, state_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] spsr_rd;
  logic        bank_we;
  logic [4:0]  bank_mode;
  logic [31:0] bank_wdata;
  logic [4:0]  cur_mode;
  logic        has_spsr;
  logic        masked;
  logic        accept;

  assign cur_mode = cpsr_q[4:0];
  assign has_spsr = mode_bank(cur_mode) != BANK_NONE;
  assign masked   = ((bus.exc_type == EXC_IRQ) && cpsr_q[7]) ||
                    ((bus.exc_type == EXC_FIQ) && cpsr_q[6]);
  assign accept   = (state_q == ST_IDLE) && bus.exc_req && exc_valid(bus.exc_type) && !masked;

  psr_spsr_bank u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .wmode (bank_mode),
    .wdata (bank_wdata),
    .rmode (cur_mode),
    .rdata (spsr_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cpsr_q  <= CPSR_RESET;
      type_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cpsr_q  <= cpsr_d;
      if (accept) begin
        type_q <= bus.exc_type;
        addr_q <= bus.exc_ret_addr;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cpsr_d     = cpsr_q;
    bank_we    = 1'b0;
    bank_mode  = cur_mode;
    bank_wdata = bus.msr_data;
    case (state_q)
      ST_IDLE: begin
        // An asserted eret wins over msr_we even when it has no effect.
        if (accept) begin
          state_d = ST_SAVE;
        end else if (bus.eret) begin
          if (has_spsr) cpsr_d = spsr_rd;
        end else if (bus.msr_we) begin
          if (bus.msr_spsr) begin
            bank_we = has_spsr;
          end else if (cur_mode == MODE_USR) begin
            cpsr_d[31:28] = bus.msr_data[31:28];
          end else begin
            cpsr_d[31:5] = bus.msr_data[31:5];
            if (mode_known(bus.msr_data[4:0])) cpsr_d[4:0] = bus.msr_data[4:0];
          end
        end
      end
      ST_SAVE: begin
        state_d      = ST_LINK;
        bank_we      = 1'b1;
        bank_mode    = exc_mode(type_q);
        bank_wdata   = cpsr_q;
        cpsr_d[4:0]  = exc_mode(type_q);
        cpsr_d[7]    = 1'b1;
        cpsr_d[5]    = 1'b0;
        if (type_q == EXC_FIQ) cpsr_d[6] = 1'b1;
      end
      ST_LINK: state_d = ST_VECT;
      ST_VECT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.M         = cpsr_q[4:0];
  assign bus.cpsr      = cpsr_q;
  assign bus.spsr      = spsr_rd;
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.write_reg = state_q == ST_LINK;
  assign bus.w_addr    = (state_q == ST_LINK) ? LINK_REG : 4'd0;
  assign bus.w_data    = (state_q == ST_LINK) ? addr_q : 32'd0;
  assign bus.write_pc  = state_q == ST_VECT;
  assign bus.pc_data   = (state_q == ST_VECT) ? exc_vector(type_q) : 32'd0;
  assign bus.exc_ack   = state_q == ST_VECT;

endmodule

// File: tb/tb_psr_ctrl.sv
// Scoreboard bench for psr_ctrl: directed scenarios plus random ops checked
// against an architectural PSR model.
module tb_psr_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  m;
    logic [31:0] cpsr;
    logic [31:0] spsr;
  } vect_t;

  logic clk;
  logic rst;
  psr_ctrl_if bus();

  psr_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_cpsr;
  logic [31:0] m_spsr[5];
  logic [31:0] link_q[$];
  vect_t       vect_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bank_of(input logic [4:0] m);
    case (m)
      5'b10001: return 0;
      5'b10010: return 1;
      5'b10011: return 2;
      5'b10111: return 3;
      5'b11011: return 4;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [4:0] tgt_mode(input logic [2:0] t);
    case (t)
      3'd0:       return 5'b11011;
      3'd1:       return 5'b10011;
      3'd2, 3'd3: return 5'b10111;
      3'd4:       return 5'b10010;
      default:    return 5'b10001;
    endcase
  endfunction

  function automatic logic [31:0] vec_of(input logic [2:0] t);
    case (t)
      3'd0:    return 32'h04;
      3'd1:    return 32'h08;
      3'd2:    return 32'h0C;
      3'd3:    return 32'h10;
      3'd4:    return 32'h18;
      default: return 32'h1C;
    endcase
  endfunction

  function automatic logic [31:0] m_cur_spsr();
    int b = bank_of(m_cpsr[4:0]);
    return (b < 0) ? 32'd0 : m_spsr[b];
  endfunction

  task automatic model_reset();
    m_cpsr = 32'h1D3;
    for (int i = 0; i < 5; i++) m_spsr[i] = 32'd0;
    link_q.delete();
    vect_q.delete();
  endtask

  task automatic model_exc(input logic [2:0] t, input logic [31:0] a, output bit acc);
    logic [4:0] tm;
    int b;
    vect_t v;
    acc = (t <= 3'd5) && !(t == 3'd4 && m_cpsr[7]) && !(t == 3'd5 && m_cpsr[6]);
    if (acc) begin
      tm = tgt_mode(t);
      b  = bank_of(tm);
      m_spsr[b]   = m_cpsr;
      m_cpsr[4:0] = tm;
      m_cpsr[7]   = 1'b1;
      m_cpsr[5]   = 1'b0;
      if (t == 3'd5) m_cpsr[6] = 1'b1;
      link_q.push_back(a);
      v.pc = vec_of(t);
      v.m = tm;
      v.cpsr = m_cpsr;
      v.spsr = m_spsr[b];
      vect_q.push_back(v);
    end
  endtask

  task automatic model_msr(input bit sel, input logic [31:0] d);
    int b = bank_of(m_cpsr[4:0]);
    bit known;
    if (sel) begin
      if (b >= 0) m_spsr[b] = d;
    end else if (m_cpsr[4:0] == 5'b10000) begin
      m_cpsr[31:28] = d[31:28];
    end else begin
      known = (bank_of(d[4:0]) >= 0) || d[4:0] == 5'b10000 || d[4:0] == 5'b11111;
      m_cpsr = {d[31:5], known ? d[4:0] : m_cpsr[4:0]};
    end
  endtask

  task automatic model_eret();
    int b = bank_of(m_cpsr[4:0]);
    if (b >= 0) m_cpsr = m_spsr[b];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    vect_t v;
    if (bus.write_reg) begin
      if (link_q.size() == 0) check("link_unexpected", {31'd0, bus.write_reg}, 32'd0);
      else begin
        e = link_q.pop_front();
        check("link_addr", {28'd0, bus.w_addr}, 32'd14);
        check("link_data", bus.w_data, e);
      end
    end else check("link_idle", bus.w_data | {28'd0, bus.w_addr}, 32'd0);
    if (bus.write_pc) begin
      if (vect_q.size() == 0) check("pc_unexpected", {31'd0, bus.write_pc}, 32'd0);
      else begin
        v = vect_q.pop_front();
        check("pc_data", bus.pc_data, v.pc);
        check("ack_with_pc", {31'd0, bus.exc_ack}, 32'd1);
        check("entry_M", {27'd0, bus.M}, {27'd0, v.m});
        check("entry_cpsr", bus.cpsr, v.cpsr);
        check("entry_spsr", bus.spsr, v.spsr);
      end
    end else check("pc_idle", bus.pc_data | {31'd0, bus.exc_ack}, 32'd0);
  end

  // ---------------- stimulus ----------------
  task automatic check_state();
    check("cpsr", bus.cpsr, m_cpsr);
    check("spsr", bus.spsr, m_cur_spsr());
    check("M", {27'd0, bus.M}, {27'd0, m_cpsr[4:0]});
  endtask

  task automatic wait_ack(input int max, output int n);
    bit found = 0;
    n = 0;
    while (n < max && !found) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.eret = 1'b0;
        bus.msr_we = 1'b0;
      end
      if (bus.exc_ack) begin
        found = 1;
        bus.exc_req = 1'b0;
      end
    end
    if (!found) begin
      check("ack_seen", {31'd0, bus.exc_ack}, 32'd1);
      bus.exc_req = 1'b0;
    end
  endtask

  task automatic do_exc(input logic [2:0] t, input logic [31:0] a);
    bit acc;
    int n;
    model_exc(t, a, acc);
    bus.exc_req = 1'b1;
    bus.exc_type = t;
    bus.exc_ret_addr = a;
    if (acc) begin
      wait_ack(8, n);
      check("ack_latency", n, 32'd3);
    end else begin
      repeat (10) @(negedge clk);
      check("busy_rejected", {31'd0, bus.busy}, 32'd0);
      bus.exc_req = 1'b0;
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic do_msr(input bit sel, input logic [31:0] d);
    bus.msr_we = 1'b1;
    bus.msr_spsr = sel;
    bus.msr_data = d;
    model_msr(sel, d);
    @(negedge clk);
    bus.msr_we = 1'b0;
    check_state();
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    model_eret();
    @(negedge clk);
    bus.eret = 1'b0;
    check_state();
  endtask

  function automatic logic [4:0] pick_mode(input bit allow_bad);
    case ($urandom_range(allow_bad ? 7 : 6, 0))
      0: return 5'b10000;
      1: return 5'b10001;
      2: return 5'b10010;
      3: return 5'b10011;
      4: return 5'b10111;
      5: return 5'b11011;
      6: return 5'b11111;
      default: return 5'($urandom_range(31, 0));
    endcase
  endfunction

  initial begin : stim
    int n;
    bit acc;
    logic [31:0] d;
    rst = 1'b1;
    bus.exc_req = 1'b0;
    bus.exc_type = 3'd0;
    bus.exc_ret_addr = 32'd0;
    bus.eret = 1'b0;
    bus.msr_we = 1'b0;
    bus.msr_spsr = 1'b0;
    bus.msr_data = 32'd0;
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("busy_in_reset", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    check_state();

    // svc entry right after reset release
    do_exc(3'd1, 32'h100);

    // irq held while I=1, then unmasked by msr
    bus.exc_req = 1'b1;
    bus.exc_type = 3'd4;
    bus.exc_ret_addr = 32'h200;
    repeat (10) @(negedge clk);
    check("irq_masked_busy", {31'd0, bus.busy}, 32'd0);
    bus.msr_we = 1'b1;
    bus.msr_spsr = 1'b0;
    bus.msr_data = 32'h53;
    model_msr(1'b0, 32'h53);
    model_exc(3'd4, 32'h200, acc);
    wait_ack(10, n);
    check("irq_unmask_latency", n, 32'd4);
    @(negedge clk);
    check_state();

    // fiq from usr and back
    do_msr(1'b0, 32'h10);
    do_exc(3'd5, 32'h300);
    do_eret();
    do_msr(1'b0, 32'hF00001DF);
    do_exc(3'd6, 32'h400);

    // simultaneous exception, eret and msr
    bus.exc_req = 1'b1;
    bus.exc_type = 3'd1;
    bus.exc_ret_addr = 32'h500;
    bus.eret = 1'b1;
    bus.msr_we = 1'b1;
    bus.msr_spsr = 1'b0;
    bus.msr_data = 32'h1F;
    model_exc(3'd1, 32'h500, acc);
    wait_ack(8, n);
    check("combo_latency", n, 32'd3);
    @(negedge clk);
    check_state();

    // reset in the middle of entry
    bus.exc_req = 1'b1;
    bus.exc_type = 3'd0;
    bus.exc_ret_addr = 32'h600;
    model_exc(3'd0, 32'h600, acc);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    bus.exc_req = 1'b0;
    #1;
    model_reset();
    check("rst_write_reg", {31'd0, bus.write_reg}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_state();
    @(negedge clk);
    check("rst_no_pc", {31'd0, bus.write_pc}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_state();

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(3, 0))
        0: do_exc(3'($urandom_range(7, 0)), $urandom & 32'hFFFF_FFFC);
        1: begin
          d = $urandom;
          d[4:0] = pick_mode(1'b1);
          do_msr(1'b0, d);
        end
        2: begin
          d = $urandom;
          d[4:0] = pick_mode(1'b0);
          do_msr(1'b1, d);
        end
        default: do_eret();
      endcase
    end

    repeat (3) @(negedge clk);
    check("queues_drained", link_q.size() + vect_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psr_ctrl.md
PSR_CTRL -- requirements
Module: psr_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-003 exc_req  in  1  exception request, level; held until exc_ack.
REQ-004 exc_type  in  3  0 undef, 1 svc, 2 pabt, 3 dabt, 4 irq, 5 fiq; 6-7 invalid.
REQ-005 exc_ret_addr  in  32  return address to place in banked r14.
REQ-006 exc_ack  out  1  one-cycle pulse: exception entry complete.
REQ-007 eret  in  1  exception return: restore CPSR from current-mode SPSR.
REQ-008 msr_we  in  1  PSR write strobe; msr_spsr in 1 selects SPSR (1) or CPSR (0); msr_data in 32 is the write value.
REQ-009 M  out  5  current mode, equals cpsr[4:0]; drives register-file M.
REQ-010 cpsr / spsr  out  32 each  CPSR; SPSR of current mode (0 in usr/sys).
REQ-011 write_reg, w_addr[3:0], w_data[31:0]  out  register-file write port.
REQ-012 write_pc, pc_data[31:0]  out  register-file PC write port.
REQ-013 busy  out  1  high in any FSM state other than IDLE.

Function
REQ-014 FSM states IDLE, SAVE, LINK, VECT; SAVE->LINK->VECT->IDLE unconditionally, one cycle each.
REQ-015 Accept in IDLE only: exc_req=1, exc_type valid, not masked (irq masked by cpsr[7], fiq by cpsr[6]); latch exc_type and exc_ret_addr, go SAVE.
REQ-016 Masked or invalid requests: stay IDLE, no ack; request remains pending until unmasked or dropped.
REQ-017 Target modes: undef 11011, svc 10011, pabt/dabt 10111, irq 10010, fiq 10001.
REQ-018 SAVE: SPSR[target] <= CPSR; CPSR[4:0] <= target; CPSR[7] <= 1; CPSR[6] <= 1 for fiq only; CPSR[5] <= 0.
REQ-019 LINK: write_reg=1, w_addr=14, w_data=latched exc_ret_addr for exactly one cycle; M already shows target mode.
REQ-020 VECT: write_pc=1, pc_data = undef 0x04, svc 0x08, pabt 0x0C, dabt 0x10, irq 0x18, fiq 0x1C; exc_ack=1 same cycle.
REQ-021 write_reg, write_pc, exc_ack are 0 in every other cycle; w_addr/w_data/pc_data hold 0 when strobes low.
REQ-022 IDLE priority same cycle: accepted exc_req > eret > msr_we; losers are dropped, not queued.
REQ-023 eret in non-usr/sys mode: CPSR <= SPSR[mode] in one cycle; in usr (10000) or sys (11111) no effect.
REQ-024 msr_we, msr_spsr=0: in usr mode only cpsr[31:28] updated; otherwise full 32-bit write; a write whose mode field is not in REQ-017/usr/sys leaves cpsr[4:0] unchanged.
REQ-025 msr_we, msr_spsr=1: writes SPSR[mode]; ignored in usr/sys.
REQ-026 eret/msr_we while busy: ignored.
REQ-027 Nested entry: new accepted exception overwrites same-mode SPSR (no stacking).

Reset
REQ-028 rst=0 at any time, including mid-FSM: CPSR=0x000001D3 (svc, I=F=A=1), all SPSRs 0, FSM IDLE, all strobes/data outputs 0, no partial write issued.
REQ-029 First exception accepted in the first rising edge after rst deasserts.

Structure
REQ-030 Mode encodings, exception-type codes, vector offsets, FSM state codes and CPSR reset value in shared header psr_defs.vh, also used by the register file.
REQ-031 One sub-module psr_spsr_bank: five SPSRs (fiq, irq, svc, abt, und), mode-indexed read/write.

Verification
REQ-032 Reset, then svc exc_req, ret 0x100 -> SAVE/LINK/VECT; r14 write 0x100; pc_data 0x08; spsr=0x1D3; M=10011; ack on 3rd cycle.
REQ-033 CPSR I=1, irq exc_req -> no ack 10 cycles; msr clears I -> entry proceeds, M=10010, pc_data 0x18.
REQ-034 fiq entry from usr (cpsr 0x10) -> cpsr=0xD1, spsr=0x10; eret -> cpsr=0x10, spsr reads 0.
REQ-035 usr mode msr_we data 0xF00001DF -> cpsr=0xF0000010.
REQ-036 exc_req, eret, msr_we same cycle -> only exception taken; rst=0 during LINK -> no write_pc, cpsr=0x1D3.
